// File: rtl/sobel_window_gen.sv
// sobel_window_gen: raster-scans an image BRAM and streams 3x3 windows centred on interior pixels
module sobel_window_gen #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int DW = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   bram_en,
  output logic [$clog2(IMG_H)+$clog2(IMG_W)-1:0] bram_addr,
  input  logic [DW-1:0]                          bram_dout,
  output logic                                   win_valid,
  input  logic                                   win_ready,
  output logic [9*DW-1:0]                        win_data,
  output logic [$clog2(IMG_H)-1:0]               win_row,
  output logic [$clog2(IMG_W)-1:0]               win_col
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = RW + CW;
  localparam logic [AW-1:0] LAST = AW'(IMG_W * IMG_H - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] rd_idx, cap_idx, addr_q;
  logic inflight;
  logic [DW-1:0] lb_a [IMG_W];
  logic [DW-1:0] lb_b [IMG_W];
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic can_issue;
  assign r = cap_idx[AW-1:CW];
  assign c = cap_idx[CW-1:0];
  assign busy = state_q != IDLE;
  assign can_issue = !inflight && (!win_valid || win_ready);
  assign bram_addr = bram_en ? rd_idx : addr_q;
  // Next state and read strobe: one read in flight, never while a window is stalled
  always_comb begin
    state_d = state_q;
    bram_en = 1'b0;
    case (state_q)
      IDLE:  state_d = start ? RUN : IDLE;
      RUN: begin
        bram_en = can_issue;
        state_d = (can_issue && rd_idx == LAST) ? DRAIN : RUN;
      end
      DRAIN: state_d = can_issue ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // Control state, counters and the 3x3 window register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      inflight  <= 1'b0;
      done      <= 1'b0;
      rd_idx    <= '0;
      cap_idx   <= '0;
      addr_q    <= '0;
      win_valid <= 1'b0;
      win_data  <= '0;
      win_row   <= '0;
      win_col   <= '0;
    end else begin
      state_q  <= state_d;
      inflight <= bram_en;
      done     <= win_valid && win_ready && win_row == RW'(IMG_H - 2) && win_col == CW'(IMG_W - 2);
      if (state_q == IDLE && start) begin
        rd_idx  <= '0;
        cap_idx <= '0;
      end
      if (bram_en) begin
        addr_q <= rd_idx;
        rd_idx <= rd_idx + AW'(1);
      end
      if (inflight) begin
        cap_idx   <= cap_idx + AW'(1);
        win_data  <= {win_data[8*DW-1:6*DW], lb_a[c], win_data[5*DW-1:3*DW], lb_b[c], win_data[2*DW-1:0], bram_dout};
        win_valid <= r >= RW'(2) && c >= CW'(2);
        win_row   <= r - RW'(1);
        win_col   <= c - CW'(1);
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end
  // Line buffers shift the column history down by one row on every captured pixel
  always_ff @(posedge clk) begin
    if (inflight) begin
      lb_a[c] <= lb_b[c];
      lb_b[c] <= bram_dout;
    end
  end
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: directed frames against a pixel-function BRAM and a window scoreboard
module tb_sobel_window_gen;
  localparam int NWIN = 126 * 126;
  localparam int NPIX = 128 * 128;
  logic clk = 1'b0;
  logic rst, start, busy, done, bram_en, win_valid, win_ready;
  logic [13:0] bram_addr;
  logic [7:0] bram_dout;
  logic [71:0] win_data;
  logic [6:0] win_row, win_col;
  logic [85:0] obs;
  logic [103:0] outs;
  int n_checks = 0, n_err = 0, cyc = 0, t0 = 0, mode = 0, rmode = 1;
  bit mon_en = 0, timing_en = 0;
  int rd_cnt, win_cnt, done_cnt, done_rel, first_rel, rd_bad, rule_bad, hold_bad;
  logic [85:0] first_win;
  logic [71:0] w21;
  assign obs = {win_row, win_col, win_data};
  assign outs = {busy, done, bram_en, bram_addr, win_valid, win_row, win_col, win_data};
  sobel_window_gen dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_row(win_row), .win_col(win_col)
  );
  function automatic logic [7:0] pix(input int m, input int r, input int c);
    return (m == 0) ? 8'(r + c) : 8'(r * 128 + c);
  endfunction
  function automatic logic [85:0] exp_win(input int m, input int k);
    int cr = 1 + k / 126;
    int cc = 1 + k % 126;
    logic [71:0] d = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        d = {d[63:0], pix(m, cr - 1 + i, cc - 1 + j)};
    return {7'(cr), 7'(cc), d};
  endfunction
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  always @(posedge clk)
    if (bram_en) bram_dout <= pix(mode, int'(bram_addr[13:7]), int'(bram_addr[6:0]));
  // win_ready driver: 0, 1 or pseudo-random, changed just after each rising edge
  initial begin
    logic [31:0] s;
    s = 32'h1234_5678;
    win_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      s ^= s << 13;
      s ^= s >> 17;
      s ^= s << 5;
      win_ready = (rmode == 2) ? s[0] : (rmode == 1);
    end
  end
  // Monitor: read order/timing, read rules, hold-while-stalled, window scoreboard, done
  initial begin
    bit prev_en, pv;
    logic [85:0] snap;
    int rel;
    prev_en = 0;
    pv = 0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        rel = cyc - t0;
        if (bram_en) begin
          if (bram_addr != 14'(rd_cnt)) rd_bad++;
          if (timing_en && rel != 1 + 2 * rd_cnt) rd_bad++;
          if (prev_en || (win_valid && !win_ready) || !busy) rule_bad++;
          rd_cnt++;
        end
        prev_en = bram_en;
        if (win_valid && first_rel < 0) first_rel = rel;
        if (pv && (!win_valid || obs !== snap)) hold_bad++;
        pv = win_valid && !win_ready;
        snap = obs;
        if (win_valid && win_ready) begin
          if (win_cnt == 0) first_win = obs;
          if (win_row == 7'd2 && win_col == 7'd1) w21 = win_data;
          if (win_cnt < NWIN) chk("window", 128'(obs), 128'(exp_win(mode, win_cnt)));
          win_cnt++;
        end
        if (done) begin
          done_cnt++;
          done_rel = rel;
        end
      end else begin
        prev_en = 0;
        pv = 0;
      end
    end
  end
  task automatic start_frame(input int m, input int rm, input bit te);
    mode = m;
    rmode = rm;
    timing_en = te;
    rd_cnt = 0; win_cnt = 0; done_cnt = 0; done_rel = -1; first_rel = -1;
    rd_bad = 0; rule_bad = 0; hold_bad = 0; first_win = '0; w21 = '0;
    t0 = cyc;
    start = 1'b1;
    mon_en = 1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask
  task automatic go_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_done(input int lim, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < lim);
    if (!done) chk({tag, "_timeout"}, 128'(done), 128'd1);
    #1;
  endtask
  initial begin
    int act, n, sen, schg;
    logic [85:0] snap2;
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_outputs", 128'(outs), 128'd0);
    rst = 1'b1;
    act = 0;
    repeat (2) begin
      @(negedge clk);
      act += int'(busy | bram_en | win_valid | done);
    end
    chk("idle_without_start", act, 0);
    go_cycle(5);
    start_frame(0, 1, 1);
    go_cycle(600);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(33000, "f1_done");
    chk("f1_first_valid_cycle", first_rel, 519);
    chk("f1_first_window", 128'(first_win), 128'({7'd1, 7'd1, 72'h000102_010203_020304}));
    chk("f1_done_cycle", done_rel, 32770);
    chk("f1_busy_at_done", 128'(busy), 128'd0);
    chk("f1_windows", win_cnt, NWIN);
    chk("f1_reads", rd_cnt, NPIX);
    chk("f1_read_order_timing", rd_bad, 0);
    chk("f1_read_rules", rule_bad, 0);
    chk("f1_done_pulses", done_cnt, 1);
    @(posedge clk);
    #1;
    start_frame(0, 0, 0);
    @(negedge clk);
    chk("done_single_pulse", 128'(done), 128'd0);
    chk("f2_busy", 128'(busy), 128'd1);
    n = 0;
    while (!win_valid && n < 700) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("f2_first_valid_cycle", first_rel, 519);
    snap2 = obs;
    sen = int'(bram_en);
    schg = 0;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      sen += int'(bram_en);
      if (!win_valid || obs !== snap2) schg++;
    end
    rmode = 1;
    chk("stall_no_read", sen, 0);
    chk("stall_hold", schg, 0);
    go_cycle(t0 + 1000);
    chk("f2_progress", 128'(win_cnt >= 2), 128'd1);
    chk("f2_read_order", rd_bad, 0);
    chk("f2_read_rules", rule_bad, 0);
    chk("f2_hold", hold_bad, 0);
    mon_en = 0;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", 128'(outs), 128'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    act = 0;
    repeat (20) begin
      @(negedge clk);
      act += int'(busy | bram_en | win_valid | done);
    end
    chk("post_reset_idle", act, 0);
    @(posedge clk);
    #1;
    start_frame(1, 2, 0);
    wait_done(60000, "f3_done");
    repeat (20) @(negedge clk);
    #1;
    chk("f3_windows", win_cnt, NWIN);
    chk("f3_reads", rd_cnt, NPIX);
    chk("f3_done_pulses", done_cnt, 1);
    chk("f3_window_2_1", 128'(w21), 128'(72'h808182_000102_808182));
    chk("f3_read_order", rd_bad, 0);
    chk("f3_read_rules", rule_bad, 0);
    chk("f3_hold", hold_bad, 0);
    chk("f3_idle_after", 128'(busy), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
